dmem_mmio: RTL and testbench

Data-memory subsystem that sits directly downstream of the pipelined MIPS core's EX/MEM stage. It consumes the core's memory-request outputs (address, memwrite, memread, store data) and returns load data combinationally, in time for the MEM/WB register. It contains a word-addressed RAM and a small memory-mapped I/O window. The window provides an output FIFO with a valid/ready drain port, for streaming AES results off-chip, and a free-running cycle counter for benchmarking.

---
 rtl/dmem_mmio.sv | 79 +++++++
 tb/tb_dmem_mmio.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/dmem_mmio.sv
// dmem_mmio: word-addressed data RAM plus MMIO window with an output FIFO and a cycle counter.
// Loads are combinational; all state updates land on posedge clk.
module dmem_mmio #(
    parameter int DEPTH_WORDS = 1024,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        memwrite,
    input  logic        memread,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready
);
    localparam int N  = $clog2(DEPTH_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [31:0] mem  [DEPTH_WORDS];
    logic [31:0] fbuf [FIFO_DEPTH];
    logic [PW-1:0] rp, wp;
    logic [PW:0]   count;
    logic          ovf;
    logic [31:0]   cyc;

    logic          ram_sel, out_sel, st_sel, cy_sel;
    logic [N-1:0]  idx;
    logic          empty, full, pop, push, push_ok;
    logic [7:0]    cnt8;
    logic [31:0]   status;

    assign ram_sel = addr[31:N+2] == '0;
    assign out_sel = addr == 32'hFFFF_0000;
    assign st_sel  = addr == 32'hFFFF_0004;
    assign cy_sel  = addr == 32'hFFFF_0008;
    assign idx     = addr[N+1:2];

    assign empty     = count == '0;
    assign full      = count == (PW+1)'(FIFO_DEPTH);
    assign out_valid = !empty;
    assign pop       = out_valid & out_ready;
    assign push      = memwrite & out_sel;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign push_ok   = push & (!full | pop);
    assign out_data  = empty ? '0 : fbuf[rp];
    assign cnt8      = 8'(count);
    assign status    = {16'b0, cnt8, 5'b0, ovf, full, empty};

    always_comb begin
        read_data = !memread ? '0 :
                    ram_sel  ? mem[idx] :
                    st_sel   ? status :
                    cy_sel   ? cyc : '0;
    end

    always_ff @(posedge clk) begin
        if (memwrite & ram_sel) mem[idx] <= write_data;
        if (push_ok) fbuf[wp] <= write_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rp    <= '0;
            wp    <= '0;
            count <= '0;
            ovf   <= 1'b0;
            cyc   <= '0;
        end else begin
            if (push_ok) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            count <= count + (PW+1)'(push_ok) - (PW+1)'(pop);
            if (push & full & !pop) ovf <= 1'b1;
            else if (memwrite & st_sel & write_data[2]) ovf <= 1'b0;
            cyc <= (memwrite & cy_sel) ? '0 : cyc + 32'd1;
        end
    end
endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio: scoreboard bench for dmem_mmio; read results and FIFO words are queued
// when stimulus is driven and compared when the DUT presents them.
module tb_dmem_mmio;
    localparam logic [31:0] OUT = 32'hFFFF_0000;
    localparam logic [31:0] STA = 32'hFFFF_0004;
    localparam logic [31:0] CYC = 32'hFFFF_0008;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = '0;
    logic        memwrite = 1'b0;
    logic        memread = 1'b0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] pend;
    bit          pend_v = 1'b0;

    dmem_mmio dut (
        .clk(clk), .reset(reset), .addr(addr), .memwrite(memwrite), .memread(memread),
        .write_data(write_data), .read_data(read_data), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One bus cycle: drive at negedge, check read_data, commit at the following posedge
    task automatic bus(input string tag, input logic [31:0] a, input bit we, input logic [31:0] wd,
                       input bit re, input logic [31:0] exp, input bit acc, input bit rdy);
        @(negedge clk);
        addr = a; memwrite = we; write_data = wd; memread = re; out_ready = rdy;
        if (acc) begin pend = wd; pend_v = 1'b1; end
        rd_q.push_back(re ? exp : 32'h0);
        #1 chk(tag, read_data, rd_q.pop_front());
    endtask

    always @(posedge clk) if (pend_v) begin exp_q.push_back(pend); pend_v = 1'b0; end

    initial forever begin
        @(negedge clk);
        #2;
        if (reset) begin
            chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            chk("out_data", out_data, exp_q.size() != 0 ? exp_q[0] : 32'h0);
            if (out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
        end
    end

    initial begin
        #6;
        chk("rst_rd", read_data, 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_data", out_data, 32'h0);
        @(negedge clk) reset = 1'b1;
        for (int i = 0; i < 4; i++) bus("idle", 32'h0, 0, 0, 0, 0, 0, 0);
        bus("cyc5", CYC, 0, 0, 1, 32'd5, 0, 0);
        bus("cyc_wr", CYC, 1, 32'h1234, 0, 0, 0, 0);
        bus("cyc_ld0", CYC, 0, 0, 1, 32'd0, 0, 0);
        bus("cyc_ld1", CYC, 0, 0, 1, 32'd1, 0, 0);
        @(negedge clk);
        force dut.cyc = 32'hFFFF_FFFF;
        addr = CYC; memread = 1'b1; memwrite = 1'b0;
        rd_q.push_back(32'hFFFF_FFFF);
        #1 chk("cyc_max", read_data, rd_q.pop_front());
        #1 release dut.cyc;
        bus("cyc_wrap", CYC, 0, 0, 1, 32'd0, 0, 0);
        bus("cyc_wrap1", CYC, 0, 0, 1, 32'd1, 0, 0);

        bus("ram_wr", 32'h10, 1, 32'hDEAD_BEEF, 0, 0, 0, 0);
        bus("ram_rd", 32'h10, 0, 0, 1, 32'hDEAD_BEEF, 0, 0);
        bus("ram_unal", 32'h12, 0, 0, 1, 32'hDEAD_BEEF, 0, 0);
        bus("ram_nord", 32'h10, 0, 0, 0, 0, 0, 0);
        bus("ram_w0", 32'h0, 1, 32'hA5A5_A5A5, 0, 0, 0, 0);
        bus("ram_top_w", 32'hFFC, 1, 32'h7777_0001, 0, 0, 0, 0);
        bus("ram_top_r", 32'hFFC, 0, 0, 1, 32'h7777_0001, 0, 0);
        bus("past_ram_w", 32'h1000, 1, 32'h1234_5678, 0, 0, 0, 0);
        bus("past_ram_r", 32'h1000, 0, 0, 1, 32'h0, 0, 0);
        bus("w0_kept", 32'h0, 0, 0, 1, 32'hA5A5_A5A5, 0, 0);
        bus("rw_pre", 32'h20, 1, 32'h1111, 0, 0, 0, 0);
        bus("rw_same", 32'h20, 1, 32'h2222, 1, 32'h1111, 0, 0);
        bus("rw_post", 32'h20, 0, 0, 1, 32'h2222, 0, 0);

        for (int i = 1; i <= 8; i++) bus("push", OUT, 1, 32'(i), 0, 0, 1, 0);
        bus("sta_full", STA, 0, 0, 1, 32'h0000_0802, 0, 0);
        bus("push_ovf", OUT, 1, 32'd9, 0, 0, 0, 0);
        bus("sta_ovf", STA, 0, 0, 1, 32'h0000_0806, 0, 0);
        bus("out_rd0", OUT, 0, 0, 1, 32'h0, 0, 0);
        for (int i = 0; i < 8; i++) bus("drain", 32'h0, 0, 0, 0, 0, 0, 1);
        bus("sta_empty", STA, 0, 0, 1, 32'h0000_0005, 0, 1);
        bus("clr", STA, 1, 32'h4, 0, 0, 0, 0);
        bus("sta_clr", STA, 0, 0, 1, 32'h0000_0001, 0, 0);

        for (int i = 11; i <= 18; i++) bus("push2", OUT, 1, 32'(i), 0, 0, 1, 0);
        bus("pushpop", OUT, 1, 32'd19, 0, 0, 1, 1);
        bus("sta_pp", STA, 0, 0, 1, 32'h0000_0802, 0, 0);
        bus("push_ovf2", OUT, 1, 32'd99, 0, 0, 0, 0);
        bus("clr2", STA, 1, 32'hFFFF_FFFB, 0, 0, 0, 0);
        bus("sta_noclr", STA, 0, 0, 1, 32'h0000_0806, 0, 0);
        bus("clr3", STA, 1, 32'h4, 0, 0, 0, 0);
        bus("sta_clr3", STA, 0, 0, 1, 32'h0000_0802, 0, 0);
        for (int i = 0; i < 8; i++) bus("drain2", 32'h0, 0, 0, 0, 0, 0, 1);
        bus("sta_e2", STA, 0, 0, 1, 32'h0000_0001, 0, 0);

        bus("ram_keep_w", 32'h40, 1, 32'hCAFE_F00D, 0, 0, 0, 0);
        for (int i = 21; i <= 23; i++) bus("push3", OUT, 1, 32'(i), 0, 0, 1, 0);
        bus("sta_3", STA, 0, 0, 1, 32'h0000_0300, 0, 0);
        @(negedge clk);
        memwrite = 1'b0; addr = STA; memread = 1'b1;
        #4 reset = 1'b0;
        exp_q.delete();
        rd_q.push_back(32'h0000_0001);
        #1 chk("rst_sta", read_data, rd_q.pop_front());
        chk("rst_valid2", 32'(out_valid), 32'h0);
        chk("rst_data2", out_data, 32'h0);
        addr = CYC;
        rd_q.push_back(32'h0);
        #1 chk("rst_cyc", read_data, rd_q.pop_front());
        @(negedge clk) reset = 1'b1;
        bus("ram_keep_r", 32'h40, 0, 0, 1, 32'hCAFE_F00D, 0, 0);
        bus("unm_w", 32'h8000_0000, 1, 32'h5555_5555, 0, 0, 0, 0);
        bus("unm_r", 32'h8000_0000, 0, 0, 1, 32'h0, 0, 0);
        bus("unm_alias", 32'h0, 0, 0, 1, 32'hA5A5_A5A5, 0, 0);
        bus("sta_unm", STA, 0, 0, 1, 32'h0000_0001, 0, 0);
        bus("idle_end", 32'h0, 0, 0, 0, 0, 0, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
